// File: rtl/board_io_pkg.sv
// Shared constants and seven-segment glyph lookup for the board I/O front end.
package board_io_pkg;

    // All segments off (segments are active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Idle level of an active-low push-button.
    localparam logic KEY_RELEASED = 1'b1;

    // Glyphs for 0-F, segment order gfedcba, active-low. Entry 0 is rightmost.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/board_io_if.sv
// CPU-side port bundle: out-port write path, run status and the in-port word.
interface board_io_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] outport_data;
    logic              outport_wr;
    logic              run;
    logic [DATA_W-1:0] inport_data;

    // CPU / Control side drives the out-port and run status.
    modport master (
        output outport_data,
        output outport_wr,
        output run,
        input  inport_data
    );

    // Board front end consumes them and returns the switch word.
    modport slave (
        input  outport_data,
        input  outport_wr,
        input  run,
        output inport_data
    );
endinterface

// File: rtl/board_io_ctrl_key_debouncer.sv
// One push-button channel: two-flop synchroniser, stability counter,
// debounced level and a one-cycle press pulse.
module key_debouncer
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic key_n_i,
    output logic key_pressed_o,
    output logic key_pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             pulse_q, pulse_d;
    logic             raw_n;

    assign raw_n = ~sync2_q;

    // Count consecutive cycles the synced level differs from the accepted level.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave a latch behind.
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        pulse_d   = 1'b0;
        if (raw_n == pressed_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            pressed_d = ~pressed_q;
            pulse_d   = ~pressed_q;    // only a new press pulses, never a release
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser and debounce state; reset discards any partial count.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            sync1_q   <= KEY_RELEASED;
            sync2_q   <= KEY_RELEASED;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            pulse_q   <= pulse_d;
        end
    end

    assign key_pressed_o = pressed_q;
    assign key_pulse_o   = pulse_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O front end for the Mini SRC top level: debounced keys, synchronised
// switches into the in-port, latched out-port shown on NUM_HEX hex digits, run LED.
// Optional: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero nibble (digit 0 always lit).
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int NUM_SW          = 8,
    parameter int NUM_HEX         = 2,
    parameter int DATA_W          = 32,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [NUM_KEYS-1:0]  KEY,
    input  logic [NUM_SW-1:0]    SW,
    board_io_if.slave            cpu,
    output logic [NUM_KEYS-1:0]  key_pressed,
    output logic [NUM_KEYS-1:0]  key_pulse,
    output logic [7*NUM_HEX-1:0] HEX,
    output logic                 LEDR_run
);

    logic [NUM_SW-1:0] sw_sync1_q, sw_sync2_q;
    logic [DATA_W-1:0] latch_q;
    logic              led_q;

    // One independent debounce channel per push-button.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key_debouncer (
            .clk_i         (CLOCK_50),
            .reset_i       (reset),
            .key_n_i       (KEY[k]),
            .key_pressed_o (key_pressed[k]),
            .key_pulse_o   (key_pulse[k])
        );
    end

    // Switch synchroniser, out-port latch and run LED; reset beats a write.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            latch_q    <= '0;
            led_q      <= 1'b0;
        end else begin
            sw_sync1_q <= SW;
            sw_sync2_q <= sw_sync1_q;
            if (cpu.outport_wr) begin
                latch_q <= cpu.outport_data;
            end
            led_q <= cpu.run;
        end
    end

    assign cpu.inport_data = DATA_W'(sw_sync2_q);
    assign LEDR_run        = led_q;

    // Each digit decodes its own nibble of the latched out-port word.
    for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
        logic [3:0] nibble;
        assign nibble = latch_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 0) begin : g_lsd
            assign HEX[7*i +: 7] = hex_to_seg(nibble);
        end else begin : g_upper
            // Blank when this digit and every digit above it are zero.
            logic upper_zero;
            assign upper_zero    = (latch_q[4*NUM_HEX-1 : 4*i] == '0);
            assign HEX[7*i +: 7] = upper_zero ? SEG_BLANK : hex_to_seg(nibble);
        end
`else
        assign HEX[7*i +: 7] = hex_to_seg(nibble);
`endif
    end

    // Out-port bits above the displayed digits are latched but not shown.
    if (4*NUM_HEX < DATA_W) begin : g_spare
        logic unused_latch_bits;
        assign unused_latch_bits = ^latch_q[DATA_W-1 : 4*NUM_HEX];
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: a cycle-level reference model pushes the
// expected outputs after every edge; a negedge monitor pops and compares.
module tb_board_io_ctrl;

    localparam int NK  = 2;
    localparam int NSW = 8;
    localparam int NH  = 4;
    localparam int DW  = 32;
    localparam int DB  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key;
    logic [NSW-1:0] sw;
    logic [NK-1:0] key_pressed, key_pulse;
    logic [7*NH-1:0] hex;
    logic          ledr_run;

    always #5 clk = ~clk;

    board_io_if #(.DATA_W(DW)) cpu_if ();

    board_io_ctrl #(
        .NUM_KEYS        (NK),
        .NUM_SW          (NSW),
        .NUM_HEX         (NH),
        .DATA_W          (DW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .KEY         (key),
        .SW          (sw),
        .cpu         (cpu_if),
        .key_pressed (key_pressed),
        .key_pulse   (key_pulse),
        .HEX         (hex),
        .LEDR_run    (ledr_run)
    );

    typedef struct packed {
        logic [NK-1:0]   pressed;
        logic [NK-1:0]   pulse;
        logic [7*NH-1:0] hex;
        logic [DW-1:0]   inport;
        logic            led;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Standard 0-F glyphs, gfedcba active-low.
    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic logic [7*NH-1:0] expected_hex(input logic [DW-1:0] word);
        logic [7*NH-1:0] r;
        int msd;
        msd = 0;
        for (int i = 0; i < NH; i++)
            if (word[4*i +: 4] != 4'h0) msd = i;
        for (int i = 0; i < NH; i++) begin
            r[7*i +: 7] = glyph[word[4*i +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
            if (i > msd) r[7*i +: 7] = 7'b1111111;
`endif
        end
        return r;
    endfunction

    // Reference model: inputs reach the logic two edges late; a key's accepted
    // level flips after DB consecutive cycles of disagreement.
    logic [NK-1:0]  m_key_hist [2];
    logic [NSW-1:0] m_sw_hist  [2];
    int             m_run      [NK];
    logic [NK-1:0]  m_pressed, m_pulse;
    logic [DW-1:0]  m_latch;
    logic           m_led;

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            m_key_hist = '{'1, '1};
            m_sw_hist  = '{'0, '0};
            for (int k = 0; k < NK; k++) m_run[k] = 0;
            m_pressed = '0;
            m_pulse   = '0;
            m_latch   = '0;
            m_led     = 1'b0;
        end else begin
            for (int k = 0; k < NK; k++) begin
                logic held;
                held       = ~m_key_hist[1][k];
                m_pulse[k] = 1'b0;
                if (held != m_pressed[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == DB) begin
                        m_pressed[k] = held;
                        m_pulse[k]   = held;
                        m_run[k]     = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_key_hist[1] = m_key_hist[0];
            m_key_hist[0] = key;
            m_sw_hist[1]  = m_sw_hist[0];
            m_sw_hist[0]  = sw;
            if (cpu_if.outport_wr) m_latch = cpu_if.outport_data;
            m_led = cpu_if.run;
        end
        e.pressed = m_pressed;
        e.pulse   = m_pulse;
        e.hex     = expected_hex(m_latch);
        e.inport  = DW'(m_sw_hist[1]);
        e.led     = m_led;
        sb_q.push_back(e);
    end

    // Monitor: compare every presented output set against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("key_pressed", 64'(key_pressed), 64'(e.pressed));
            check("key_pulse",   64'(key_pulse),   64'(e.pulse));
            check("hex",         64'(hex),         64'(e.hex));
            check("inport_data", 64'(cpu_if.inport_data), 64'(e.inport));
            check("ledr_run",    64'(ledr_run),    64'(e.led));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset                = 1'b1;
        key                  = 2'b11;
        sw                   = '0;
        cpu_if.outport_data  = '0;
        cpu_if.outport_wr    = 1'b0;
        cpu_if.run           = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(2);

        // Clean press and release of KEY[0].
        key[0] = 1'b0;
        cycles(10);
        key[0] = 1'b1;
        cycles(10);

        // Bouncing KEY[1]: low 3, high 1, then held low.
        key[1] = 1'b0;
        cycles(3);
        key[1] = 1'b1;
        cycles(1);
        key[1] = 1'b0;
        cycles(10);
        key[1] = 1'b1;
        cycles(10);

        // Out-port write showing "C0".
        cpu_if.outport_data = 32'h0000_00C0;
        cpu_if.outport_wr   = 1'b1;
        cycles(1);
        cpu_if.outport_wr   = 1'b0;
        cycles(3);

        // Switch word into the in-port.
        sw = 8'hC0;
        cpu_if.run = 1'b1;
        cycles(4);

        // Reset during a partial debounce count, with a simultaneous write.
        cpu_if.outport_data = '0;
        cpu_if.outport_wr   = 1'b1;
        cycles(1);
        cpu_if.outport_wr   = 1'b0;
        key[0] = 1'b0;
        cycles(4);
        reset               = 1'b1;
        cpu_if.outport_data = 32'hFFFF_FFFF;
        cpu_if.outport_wr   = 1'b1;
        cycles(1);
        reset             = 1'b0;
        cpu_if.outport_wr = 1'b0;
        cycles(10);
        key[0] = 1'b1;
        cycles(10);

        // Randomised traffic: slow-changing keys so presses get accepted.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(15) == 0) key[k] = ~key[k];
            sw                  = NSW'($urandom);
            cpu_if.run          = 1'($urandom);
            cpu_if.outport_wr   = ($urandom_range(7) == 0);
            cpu_if.outport_data = (($urandom_range(3) == 0) ? 32'($urandom_range(255)) : $urandom);
            reset               = ($urandom_range(299) == 0);
            cycles(1);
        end
        reset             = 1'b0;
        cpu_if.outport_wr = 1'b0;
        cycles(3);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the bench cannot hang.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
